// File: rtl/display_pkg.sv
// display_pkg: page-count helpers and shared constants; DISP_FLAG_PAGE_EN adds the ZF/OF flag page.
package display_pkg;
  localparam int FLAG_ZF_BIT = 0;
  localparam int FLAG_OF_BIT = 1;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO = 1'b1;
  function automatic int ndata(int data_w, int led_w);
    return data_w / led_w;
  endfunction
  function automatic int npages(int data_w, int led_w);
`ifdef DISP_FLAG_PAGE_EN
    return ndata(data_w, led_w) + 1;
`else
    return ndata(data_w, led_w);
`endif
  endfunction
  function automatic int psel_w(int data_w, int led_w);
    return $clog2(ndata(data_w, led_w) + 1);
  endfunction
endpackage

// File: rtl/result_display_scan_if.sv
// result_display_scan_if: datapath-side inputs and LED-side outputs of the result pager.
interface result_display_scan_if import display_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int LED_W = 8,
  parameter int PSEL_W = psel_w(DATA_W, LED_W)
);
  logic [DATA_W-1:0] data_in;
  logic zf;
  logic of;
  logic load;
  logic mode;
  logic [PSEL_W-1:0] page_sel;
  logic [LED_W-1:0] led;
  logic [PSEL_W-1:0] page_idx;
  logic page_wrap;
  modport master(output data_in, zf, of, load, mode, page_sel, input led, page_idx, page_wrap);
  modport slave(input data_in, zf, of, load, mode, page_sel, output led, page_idx, page_wrap);
endinterface

// File: rtl/dwell_timer.sv
// dwell_timer: one-cycle tick every DWELL cycles while run is high; clears while run is low.
module dwell_timer #(
  parameter int DWELL = 50_000_000,
  parameter int CNT_W = $clog2(DWELL) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);
  logic [CNT_W-1:0] cnt;
  assign tick = run && cnt == CNT_W'(DWELL - 1);
  always_ff @(posedge clk)
    cnt <= (rst || !run || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/result_display_scan.sv
// result_display_scan: snapshots a result and pages it onto LEDs, manually or on a dwell timer.
// Define DISP_FLAG_PAGE_EN to add a ZF/OF page after the data pages.
module result_display_scan import display_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int LED_W = 8,
  parameter int DWELL = 50_000_000
) (
  input logic clk,
  input logic rst,
  result_display_scan_if.slave bus
);
  localparam int NDATA = ndata(DATA_W, LED_W);
  localparam int NPAGES = npages(DATA_W, LED_W);
  localparam int PSEL_W = psel_w(DATA_W, LED_W);
  localparam int CNT_W = $clog2(DWELL) + 1;
  localparam logic [PSEL_W-1:0] LAST = PSEL_W'(NPAGES - 1);
  logic tick, auto_on, wrap_next;
  logic [PSEL_W-1:0] cur, page_next;
  logic [DATA_W-1:0] snap, snap_next;
  logic [LED_W-1:0] led_next, flag_led;
  dwell_timer #(.DWELL(DWELL), .CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .run(auto_on),
    .tick(tick)
  );
  // LEDs follow the next-state page and snapshot so every change shows after one cycle
  always_comb begin
    auto_on = bus.mode == MODE_AUTO;
    cur = bus.page_idx <= LAST ? bus.page_idx : '0;
    page_next = bus.mode == MODE_MANUAL ? bus.page_sel : !tick ? cur : cur == LAST ? '0 : cur + 1'b1;
    wrap_next = auto_on && tick && cur == LAST;
    snap_next = bus.load ? bus.data_in : snap;
    led_next = page_next == PSEL_W'(NDATA) ? flag_led : '0;
    for (int i = 0; i < NDATA; i++)
      if (page_next == PSEL_W'(i)) led_next = snap_next[i*LED_W +: LED_W];
  end
`ifdef DISP_FLAG_PAGE_EN
  logic snap_zf, snap_of, zf_next, of_next;
  always_comb begin
    zf_next = bus.load ? bus.zf : snap_zf;
    of_next = bus.load ? bus.of : snap_of;
    flag_led = '0;
    flag_led[FLAG_ZF_BIT] = zf_next;
    flag_led[FLAG_OF_BIT] = of_next;
  end
  always_ff @(posedge clk)
    if (rst) {snap_zf, snap_of} <= '0;
    else {snap_zf, snap_of} <= {zf_next, of_next};
`else
  logic unused_flags;
  assign unused_flags = ^{bus.zf, bus.of, FLAG_ZF_BIT, FLAG_OF_BIT};
  assign flag_led = '0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      snap <= '0;
      bus.led <= '0;
      bus.page_idx <= '0;
      bus.page_wrap <= 1'b0;
    end else begin
      snap <= snap_next;
      bus.led <= led_next;
      bus.page_idx <= page_next;
      bus.page_wrap <= wrap_next;
    end
endmodule

// File: tb/tb_result_display_scan.sv
// tb_result_display_scan: directed and random stimulus against a behavioural pager model.
module tb_result_display_scan;
  localparam int DATA_W = 32;
  localparam int LED_W = 8;
  localparam int DWELL = 4;
  localparam int NDATA = 4;
  localparam int PSEL_W = 3;
`ifdef DISP_FLAG_PAGE_EN
  localparam int NP = 5;
  localparam bit FLAGS = 1'b1;
  int seq[20] = '{0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,4,4,0};
  localparam int WRAP_AT = 19;
`else
  localparam int NP = 4;
  localparam bit FLAGS = 1'b0;
  int seq[20] = '{0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,0,0,0,1};
  localparam int WRAP_AT = 15;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  result_display_scan_if #(.DATA_W(DATA_W), .LED_W(LED_W), .PSEL_W(PSEL_W)) bus();
  result_display_scan #(.DATA_W(DATA_W), .LED_W(LED_W), .DWELL(DWELL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_snap = '0;
  logic m_zf = 1'b0, m_of = 1'b0, m_wrap = 1'b0;
  int m_page = 0, m_cnt = 0;
  bit m_valid = 1'b0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_led(int page);
    if (page < NDATA) return 8'(m_snap >> (LED_W * page));
    if (FLAGS && page == NDATA) return {6'b0, m_of, m_zf};
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    int p;
    if (rst) begin
      m_snap = '0; m_zf = 0; m_of = 0; m_page = 0; m_cnt = 0; m_wrap = 0;
    end else begin
      if (bus.load) begin
        m_snap = bus.data_in; m_zf = bus.zf; m_of = bus.of;
      end
      m_wrap = 0;
      if (bus.mode) begin
        p = m_page < NP ? m_page : 0;
        if (m_cnt == DWELL - 1) begin
          m_cnt = 0;
          m_wrap = (p == NP - 1);
          p = (p + 1) % NP;
        end else m_cnt++;
        m_page = p;
      end else begin
        m_cnt = 0;
        m_page = int'(bus.page_sel);
      end
    end
    m_valid = 1'b1;
  end

  always @(posedge clk) begin
    #2;
    if (m_valid) begin
      check("model_led", 32'(bus.led), 32'(exp_led(m_page)));
      check("model_page", 32'(bus.page_idx), 32'(m_page));
      check("model_wrap", 32'(bus.page_wrap), 32'(m_wrap));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int k, wraps, wrap_at;
    bus.data_in = '1; bus.load = 1; bus.zf = 0; bus.of = 0; bus.mode = 0; bus.page_sel = 0;
    step(); step();
    check("rst_led", 32'(bus.led), 32'h00);
    check("rst_page", 32'(bus.page_idx), 0);
    check("rst_wrap", 32'(bus.page_wrap), 0);
    rst = 0; bus.load = 0;
    step();
    check("post_rst_led", 32'(bus.led), 32'h00);
    bus.load = 1; bus.data_in = 32'hA1B2C3D4; bus.page_sel = 0;
    step();
    bus.load = 0;
    check("page0", 32'(bus.led), 32'hD4);
    bus.page_sel = 1; step(); check("page1", 32'(bus.led), 32'hC3);
    bus.page_sel = 2; step(); check("page2", 32'(bus.led), 32'hB2);
    bus.page_sel = 3; step(); check("page3", 32'(bus.led), 32'hA1);
    bus.load = 1; bus.zf = 1; bus.of = 0; bus.page_sel = 4;
    step();
    check("flag_zf", 32'(bus.led), FLAGS ? 32'h01 : 32'h00);
    bus.zf = 0; bus.of = 1;
    step();
    check("flag_of", 32'(bus.led), FLAGS ? 32'h02 : 32'h00);
    bus.load = 0;
    for (int s = 5; s < 8; s++) begin
      bus.page_sel = 3'(s);
      step();
      check("oor_page", 32'(bus.led), 32'h00);
    end
    bus.page_sel = 0;
    step();
    bus.mode = 1;
    wraps = 0; wrap_at = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("auto_seq", 32'(bus.page_idx), 32'(seq[i]));
      if (bus.page_wrap) begin wraps++; wrap_at = i; end
    end
    check("wrap_count", 32'(wraps), 1);
    check("wrap_pos", 32'(wrap_at), 32'(WRAP_AT));
    k = 0;
    while (bus.page_idx != 3'd2 && k < 40) begin step(); k++; end
    check("reach_p2", 32'(k < 40), 1);
    rst = 1;
    step();
    rst = 0;
    check("midrst_led", 32'(bus.led), 32'h00);
    check("midrst_page", 32'(bus.page_idx), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst_hold", 32'(bus.page_idx), 0);
    end
    step();
    check("midrst_adv", 32'(bus.page_idx), 1);
    bus.mode = 0; bus.page_sel = 7;
    step();
    check("oor_manual", 32'(bus.page_idx), 7);
    bus.mode = 1;
    step();
    check("oor_entry", 32'(bus.page_idx), 0);
    for (int i = 0; i < 600; i++) begin
      bus.load = ($urandom_range(0, 2) == 0);
      bus.data_in = $urandom;
      bus.zf = 1'($urandom);
      bus.of = 1'($urandom);
      if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
      bus.page_sel = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
